// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises a NUM_OCTETS*8-bit word onto a UART line as
// back-to-back 8N1 frames. The most-significant octet goes first, and bits
// within an octet go LSB first.
// Optional feature macro: PARITY_EN adds an even-parity bit between the
// data bits and the stop bit, which makes an 11-bit frame.
module uart_word_tx #(
  parameter int unsigned CLKS_PER_BIT = 432,
  parameter int unsigned NUM_OCTETS   = 16
) (
  input  logic                    CLK_IN,
  input  logic                    resetIn,
  input  logic [NUM_OCTETS*8-1:0] DATA_IN,
  input  logic                    DATA_VALID,
  output logic                    READY,
  output logic                    UART_TX,
  output logic                    BUSY,
  output logic                    DONE
);

  localparam int unsigned WORD_W = NUM_OCTETS * 8;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned OCT_W  = (NUM_OCTETS > 1) ? $clog2(NUM_OCTETS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [OCT_W-1:0]  OCT_FIRST = OCT_W'(NUM_OCTETS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [OCT_W-1:0]    octet_q, octet_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;

  logic                baud_end;
  logic [2:0]          bit_inc;
  logic [7:0]          cur_octet;

  // The word is shifted left by one octet after each frame, so the octet
  // on the wire always sits in the top byte. octet_q only tracks how many
  // octets remain.
  assign cur_octet = shreg_q[WORD_W-1 -: 8];
  assign baud_end  = (baud_q == BAUD_LAST);
  assign bit_inc   = bit_q + 3'd1;

  assign UART_TX = tx_q;
  assign DONE    = done_q;
  assign READY   = (state_q == IDLE);
  assign BUSY    = (state_q != IDLE);

  // State, counters, shift register and the registered line output
  always_ff @(posedge CLK_IN or negedge resetIn) begin
    if (!resetIn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      octet_q <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      octet_q <= octet_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. tx_d holds the line level for the state being
  // entered, so the line changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    octet_d = octet_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (DATA_VALID) begin
          state_d = START;
          shreg_d = DATA_IN;
          octet_d = OCT_FIRST;
          bit_d   = '0;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = cur_octet[0];
        end
      end

      DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = PARITY;
            tx_d    = ^cur_octet;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_inc;
            tx_d  = cur_octet[bit_inc];
          end
        end
      end

`ifdef PARITY_EN
      PARITY: begin
        if (baud_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      STOP: begin
        if (baud_end) begin
          if (octet_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            // Next start bit follows directly, with no idle gap
            state_d = START;
            octet_d = octet_q - 1'b1;
            shreg_d = shreg_q << 8;
            tx_d    = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: scoreboard bench for uart_word_tx. Octets are queued when
// a word is sent, and a line monitor pops and compares them as frames arrive.
// It honours PARITY_EN in the same way as the design.
module tb_uart_word_tx;

  localparam int unsigned CPB  = 8;
  localparam int unsigned NOCT = 16;
  localparam int unsigned W    = NOCT * 8;
`ifdef PARITY_EN
  localparam int unsigned FRAME = 11;
`else
  localparam int unsigned FRAME = 10;
`endif
  localparam int unsigned WORD_CYC = NOCT * FRAME * CPB;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic [W-1:0] data_in    = '0;
  logic         data_valid = 1'b0;
  logic         ready, tx, busy, done;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  logic [7:0]   sb_q[$];
  logic         aborted  = 1'b0;

  always #5 clk = ~clk;

  uart_word_tx #(.CLKS_PER_BIT(CPB), .NUM_OCTETS(NOCT)) dut (
    .CLK_IN    (clk),
    .resetIn   (rst_n),
    .DATA_IN   (data_in),
    .DATA_VALID(data_valid),
    .READY     (ready),
    .UART_TX   (tx),
    .BUSY      (busy),
    .DONE      (done)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = int'(NOCT) - 1; i >= 0; i--) sb_q.push_back(w[i*8 +: 8]);
  endtask

  // Presents a word for one cycle and returns on the first negedge of its start bit
  task automatic send_word(input logic [W-1:0] w);
    int unsigned k;
    k = 0;
    while (ready !== 1'b1 && k < 2 * WORD_CYC) begin
      @(negedge clk);
      k++;
    end
    check_eq("ready_before_send", W'(ready), W'(1));
    push_word(w);
    data_in    = w;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = W'({$urandom(), $urandom(), $urandom(), $urandom()});
    check_eq("accept_ready_low", W'(ready), W'(0));
    check_eq("accept_busy_high", W'(busy), W'(1));
    check_eq("accept_start_bit", W'(tx), W'(0));
  endtask

  task automatic wait_done(output int unsigned cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 2 * WORD_CYC) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("done_seen", W'(done), W'(1));
  endtask

  // Called on the negedge where DONE is high
  task automatic check_end_of_word();
    check_eq("end_ready", W'(ready), W'(1));
    check_eq("end_busy", W'(busy), W'(0));
    check_eq("end_line_high", W'(tx), W'(1));
    check_eq("sb_drained", W'(sb_q.size()), W'(0));
    @(negedge clk);
    check_eq("done_one_cycle", W'(done), W'(0));
  endtask

  task automatic run_len(input logic lvl, output int unsigned n);
    n = 0;
    while (tx === lvl && n < 4 * FRAME * CPB) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Line monitor: samples every bit in the middle, then checks the frame against the scoreboard
  initial begin : monitor
    logic [7:0] oct;
    logic [7:0] exp_oct;
    logic       par;
    oct = '0;
    par = 1'b0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        tick(CPB / 2);
        if (!aborted) check_eq("start_bit", W'(tx), W'(0));
        for (int i = 0; i < 8; i++) begin
          tick(CPB);
          oct[i] = tx;
        end
`ifdef PARITY_EN
        tick(CPB);
        par = tx;
`endif
        tick(CPB);
        if (!aborted) begin
          check_eq("stop_bit", W'(tx), W'(1));
          check_eq("sb_nonempty", W'(sb_q.size() != 0), W'(1));
          if (sb_q.size() != 0) begin
            exp_oct = sb_q.pop_front();
            check_eq("octet", W'(oct), W'(exp_oct));
`ifdef PARITY_EN
            check_eq("parity", W'(par), W'(^exp_oct));
`endif
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned cyc;
    int unsigned runs[$];
    logic [W-1:0] word_a;
    logic [W-1:0] word_b;

    // 1: reset and quiet idle line
    #50;
    check_eq("reset_outputs", W'({tx, ready, busy, done}), W'(4'b1100));
    #50;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle_quiet", W'({tx, ready, busy, done}), W'(4'b1100));
    end

    // 2: small value, so only the two low octets are non-zero; total word length
    send_word(W'(920));
    wait_done(cyc);
    check_eq("word_cycles", W'(cyc), W'(WORD_CYC));
    check_end_of_word();

    // 3: alternating octets; start-bit length and no gap between frames
    tick(5);
    send_word(128'hFF00FF00FF00FF00FF00FF00FF00FF00);
`ifdef PARITY_EN
    runs = '{1, 8, 1, 1, 10, 1};
`else
    runs = '{1, 9, 9, 1};
`endif
    for (int i = 0; i < runs.size(); i++) begin
      run_len((i % 2) == 1, cyc);
      check_eq("line_run", W'(cyc), W'(runs[i] * CPB));
    end
    wait_done(cyc);
    check_end_of_word();

    // 4: ignored request mid-word, then a back-to-back accept at DONE
    word_a = 128'h0123456789ABCDEFFEDCBA9876543210;
    word_b = 128'hC0FFEE0012345678DEADBEEF5A5AA5A5;
    send_word(word_a);
    tick(5 * FRAME * CPB + 2 * CPB);
    data_in    = 128'h11111111222222223333333344444444;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check_eq("ignored_ready", W'(ready), W'(0));
    check_eq("ignored_busy", W'(busy), W'(1));
    tick(3 * FRAME * CPB);
    push_word(word_b);
    data_in    = word_b;
    data_valid = 1'b1;
    wait_done(cyc);
    check_eq("b2b_ready_at_done", W'(ready), W'(1));
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = '0;
    check_eq("b2b_start_bit", W'(tx), W'(0));
    check_eq("b2b_busy", W'(busy), W'(1));
    check_eq("b2b_ready_low", W'(ready), W'(0));
    wait_done(cyc);
    check_eq("b2b_word_cycles", W'(cyc), W'(WORD_CYC));
    check_end_of_word();

    // 5: asynchronous reset in the middle of octet 8, then a clean word
    send_word({4{32'h5A5A3C3C}});
    tick(7 * FRAME * CPB + 3 * CPB + CPB / 2);
    #2;
    aborted = 1'b1;
    rst_n   = 1'b0;
    #1;
    check_eq("async_rst_outputs", W'({tx, ready, busy, done}), W'(4'b1100));
    tick(2 * FRAME * CPB);
    sb_q.delete();
    aborted = 1'b0;
    rst_n   = 1'b1;
    tick(3);
    check_eq("post_rst_idle", W'({tx, ready, busy, done}), W'(4'b1100));
    send_word({4{32'hAA11BB11}});
    wait_done(cyc);
    check_eq("post_rst_word_cycles", W'(cyc), W'(WORD_CYC));
    check_end_of_word();

    tick(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
